// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing of a shared datapath.
// Optional performance counters are enabled by defining RV_CTRL_PERF_CNT_EN.
module rv32i_mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [1:0]  RESET_PC_SEL   = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_rdy,
  output logic        ir_we,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        br_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rdy,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        halted,
  output logic        retired,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] C_LUI    = 4'd0;
  localparam logic [3:0] C_AUIPC  = 4'd1;
  localparam logic [3:0] C_JAL    = 4'd2;
  localparam logic [3:0] C_JALR   = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_LOAD   = 4'd5;
  localparam logic [3:0] C_STORE  = 4'd6;
  localparam logic [3:0] C_OPIMM  = 4'd7;
  localparam logic [3:0] C_OP     = 4'd8;
  localparam logic [3:0] C_FENCE  = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic       B_RS2  = 1'b0;
  localparam logic       B_IMM  = 1'b1;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_CMP   = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_pend_q, trap_pend_d;

  logic [3:0] dec_cls;
  logic       dec_legal;
  logic       dec_sys;
  logic       wait_c;
  logic [1:0] alu_a_c;
  logic       alu_b_c;
  logic [1:0] alu_op_c;

  // funct7b5 is resolved by the datapath's ALU decoder whenever alu_op selects funct decoding.
  logic unused_funct7b5;
  assign unused_funct7b5 = funct7b5;

  function automatic logic [2:0] imm_of(input logic [3:0] cls);
    case (cls)
      C_STORE:        imm_of = IMM_S;
      C_BRANCH:       imm_of = IMM_B;
      C_LUI, C_AUIPC: imm_of = IMM_U;
      C_JAL:          imm_of = IMM_J;
      default:        imm_of = IMM_I;
    endcase
  endfunction

  // Opcode classification of the freshly loaded instruction register.
  always_comb begin
    dec_cls   = C_OP;
    dec_legal = 1'b1;
    dec_sys   = 1'b0;
    case (opcode)
      OPC_LUI:    dec_cls = C_LUI;
      OPC_AUIPC:  dec_cls = C_AUIPC;
      OPC_JAL:    dec_cls = C_JAL;
      OPC_JALR: begin
        dec_cls   = C_JALR;
        dec_legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec_cls   = C_BRANCH;
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD:   dec_cls = C_LOAD;
      OPC_STORE:  dec_cls = C_STORE;
      OPC_OPIMM:  dec_cls = C_OPIMM;
      OPC_OP:     dec_cls = C_OP;
      OPC_MISC:   dec_cls = C_FENCE;
      OPC_SYSTEM: begin
        dec_sys   = 1'b1;
        dec_legal = 1'b0;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // ALU operand/operation per latched class; held from EXEC through WB so JALR's target stays valid.
  always_comb begin
    alu_a_c  = A_RS1;
    alu_b_c  = B_RS2;
    alu_op_c = ALU_ADD;
    case (cls_q)
      C_LUI: begin
        alu_a_c = A_ZERO;
        alu_b_c = B_IMM;
      end
      C_AUIPC, C_JAL: begin
        alu_a_c = A_PC;
        alu_b_c = B_IMM;
      end
      C_JALR, C_LOAD, C_STORE: alu_b_c = B_IMM;
      C_OPIMM: begin
        alu_b_c  = B_IMM;
        alu_op_c = ALU_FUNCT;
      end
      C_OP:     alu_op_c = ALU_FUNCT;
      C_BRANCH: alu_op_c = ALU_CMP;
      default: ;
    endcase
  end

  // Next state and Moore/handshake outputs.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    wait_c    = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    imm_sel   = IMM_I;
    alu_src_a = A_RS1;
    alu_src_b = B_RS2;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    retired   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_c = 1'b1;
          if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
      end
      S_DECODE: begin
        imm_sel = imm_of(dec_cls);
        cls_d   = dec_cls;
        if (dec_sys) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ECALL;
        end else if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_sel   = imm_of(cls_q);
        alu_src_a = alu_a_c;
        alu_src_b = alu_b_c;
        alu_op    = alu_op_c;
        case (cls_q)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          C_FENCE: begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        imm_sel   = imm_of(cls_q);
        alu_src_a = alu_a_c;
        alu_src_b = alu_b_c;
        alu_op    = alu_op_c;
        dmem_req  = 1'b1;
        dmem_we   = (cls_q == C_STORE);
        if (dmem_rdy) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_c = 1'b1;
          if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
      end
      S_WB: begin
        imm_sel   = imm_of(cls_q);
        alu_src_a = alu_a_c;
        alu_src_b = alu_b_c;
        alu_op    = alu_op_c;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
        case (cls_q)
          C_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          C_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALU;
          end
          C_LOAD:  wb_sel = WB_LOAD;
          default: ;
        endcase
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase

    // Wait counter restarts on any transition and saturates while stalled.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    trap_pend_d = (state_d == S_TRAP) && (state_q != S_TRAP);

    if (!rst_n) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      imm_sel   = IMM_I;
      alu_src_a = A_RS1;
      alu_src_b = B_RS2;
      alu_op    = ALU_ADD;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = RESET_PC_SEL;
      retired   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cls_q       <= C_FENCE;
      cnt_q       <= '0;
      cause_q     <= CAUSE_ILLEGAL;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      trap_pend_q <= trap_pend_d;
    end
  end

  assign trap       = rst_n & trap_pend_q;
  assign halted     = rst_n & (state_q == S_TRAP);
  assign trap_cause = rst_n ? cause_q : CAUSE_ILLEGAL;

`ifdef RV_CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycles_d  = (state_q != S_TRAP) ? perf_cycles_q + 32'd1 : perf_cycles_q;
    perf_instret_d = retired ? perf_instret_q + 32'd1 : perf_instret_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_q  <= 32'd0;
      perf_instret_q <= 32'd0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_instret = perf_instret_q;
`else
  assign perf_cycles  = 32'd0;
  assign perf_instret = 32'd0;
`endif

endmodule
